// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - Iterative AES InvMixColumns, COLS_PER_CYCLE_P columns per clock
// Handshake: v_i/ready_o in, v_o/yumi_i out; one state in flight at a time.
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE_P = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [127:0] block_i,
    output logic         v_o,
    input  logic         yumi_i,
    output logic [127:0] mixed_block_o
);

    generate
        if (!(COLS_PER_CYCLE_P == 1 || COLS_PER_CYCLE_P == 2 || COLS_PER_CYCLE_P == 4)) begin : g_bad_param
            $error("inv_mix_columns_iter: COLS_PER_CYCLE_P must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE_P);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE_P);

    state_t         state_r, state_next;
    logic [1:0]     col_r;
    logic [127:0]   work_r, work_next;
    logic [1:0]     col_idx;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] s [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[31-8*i -: 8];
            x2[i] = xtime(s[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ s[i];
            mb[i] = x8[i] ^ x2[i] ^ s[i];
            md[i] = x8[i] ^ x4[i] ^ s[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // col_r is always a multiple of the group size, so col_r+g never wraps inside a group
    always_comb begin
        work_next = work_r;
        col_idx   = '0;
        for (int g = 0; g < COLS_PER_CYCLE_P; g++) begin
            col_idx = col_r + 2'(g);
            work_next[{col_idx, 5'd0} +: 32] = inv_col(work_r[{col_idx, 5'd0} +: 32]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_next;
    end

    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    if (v_i) state_next = BUSY;
            BUSY:    if (col_r == LAST_COL) state_next = DONE;
            DONE:    if (yumi_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_r == IDLE);
        v_o     = (state_r == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_r  <= '0;
            work_r <= '0;
        end else begin
            case (state_r)
                IDLE: if (v_i) begin
                    work_r <= block_i;
                    col_r  <= '0;
                end
                BUSY: begin
                    work_r <= work_next;
                    col_r  <= col_r + COL_STEP;
                end
                default: ;
            endcase
        end
    end

    assign mixed_block_o = work_r;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule
